// File: rtl/wb_pkg.sv
// Shared Wishbone B4 encodings and slave FSM state type.
// Imported by the register-file slave and its storage core.
package wb_pkg;

    // Cycle type identifier (cti_i)
    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    // Burst type extension (bte_i); only linear is served
    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    // How the pending access will terminate
    typedef enum logic {
        RETURN_ACK = 1'b0,
        RETURN_ERR = 1'b1
    } ret_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_BURST
    } wb_slv_state_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/wb_regfile_core.sv
// Register storage with per-lane write enables and async reset.
// Ports: clk/rst, one lane-masked write port, one combinational read port.
module wb_regfile_core #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    GRANULE     = 8,
    parameter int                    NUM_REGS    = 16,
    parameter int                    IDX_W       = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [DATA_WIDTH/GRANULE-1:0] wr_sel,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= RESET_VALUE;
            end
        end else if (wr_en) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_idx == IDX_W'(r)) begin
                    for (int g = 0; g < SEL_WIDTH; g++) begin
                        if (wr_sel[g]) begin
                            mem[r][g*GRANULE +: GRANULE] <=
                                wr_data[g*GRANULE +: GRANULE];
                        end
                    end
                end
            end
        end
    end

    // Indices past the last register read as zero (burst look-ahead)
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rd_idx == IDX_W'(r)) begin
                rd_data = mem[r];
            end
        end
    end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 slave: register bank with wait states, RO protection,
// linear incrementing bursts. Ports: Wishbone slave signals (_i/_o).
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    GRANULE     = 8,
    parameter int                    NUM_REGS    = 16,
    parameter int                    BASE_ADDR   = 0,
    parameter int                    WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ADDR_WIDTH-1:0]         adr_i,
    input  logic [DATA_WIDTH-1:0]         dat_i,
    output logic [DATA_WIDTH-1:0]         dat_o,
    input  logic [DATA_WIDTH/GRANULE-1:0] sel_i,
    input  logic                          we_i,
    input  logic                          cyc_i,
    input  logic                          stb_i,
    input  logic [2:0]                    cti_i,
    input  logic [1:0]                    bte_i,
    output logic                          ack_o,
    output logic                          err_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
    localparam int LSB       = $clog2(SEL_WIDTH);
    // One spare bit so a burst pointer can step past the last register
    localparam int IDX_W     = $clog2(NUM_REGS) + 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    wb_slv_state_t state_q, state_d;

    logic [IDX_W-1:0]      ptr_q;
    logic                  we_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    ret_t                  ret_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] rd_q;

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic [IDX_W-1:0]      idx_dec;
    logic                  dec_err;
    logic                  req;
    logic                  beat;
    logic                  beat_err;

    logic                  wr_en;
    logic [SEL_WIDTH-1:0]  wr_sel;
    logic [IDX_W-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    function automatic logic is_ro(input logic [IDX_W-1:0] i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (i == IDX_W'(k)) r = RO_MASK[k];
        end
        return r;
    endfunction

    assign req = cyc_i & stb_i;

    always_comb begin
        off      = adr_i - ADDR_WIDTH'(BASE_ADDR);
        idx_full = off >> LSB;
        idx_dec  = IDX_W'(idx_full);
        dec_err  = (|(adr_i & ADDR_WIDTH'(SEL_WIDTH - 1)))
                 | (adr_i < ADDR_WIDTH'(BASE_ADDR))
                 | (idx_full >= ADDR_WIDTH'(NUM_REGS))
                 | (we_i & (|sel_i) & is_ro(idx_dec))
                 | ((cti_i == CTI_INCR) & (bte_i != BTE_LINEAR));
    end

    // Follow-on burst beats: range and RO are checked per beat
    assign beat     = (state_q == ST_BURST) & cyc_i & stb_i;
    assign beat_err = (ptr_q >= IDX_W'(NUM_REGS))
                    | (we_q & (|sel_i) & is_ro(ptr_q));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!cyc_i)                  state_d = ST_IDLE;
                else if (cnt_q == WAIT_LAST) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (ret_q == RETURN_ACK && cti_i == CTI_INCR && cyc_i)
                    state_d = ST_BURST;
                else
                    state_d = ST_IDLE;
            end
            ST_BURST: begin
                if (!cyc_i)
                    state_d = ST_IDLE;
                else if (stb_i && (beat_err || cti_i == CTI_EOB))
                    state_d = ST_IDLE;
            end
        endcase
    end

    // Writes commit on the edge at which the master samples ack_o.
    // rd_addr looks one word ahead so the next beat's data is registered.
    always_comb begin
        ack_o   = 1'b0;
        err_o   = 1'b0;
        wr_sel  = sel_q;
        rd_addr = ptr_q;
        unique case (state_q)
            ST_IDLE: rd_addr = idx_dec;
            ST_WAIT: rd_addr = ptr_q;
            ST_RESP: begin
                ack_o   = (ret_q == RETURN_ACK);
                err_o   = (ret_q == RETURN_ERR);
                rd_addr = ptr_q + IDX_W'(1);
            end
            ST_BURST: begin
                ack_o   = beat & ~beat_err;
                err_o   = beat & beat_err;
                wr_sel  = sel_i;
                rd_addr = beat ? ptr_q + IDX_W'(1) : ptr_q;
            end
        endcase
        wr_en = ack_o & we_q;
        dat_o = (ack_o & ~we_q) ? rd_q : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            ret_q <= RETURN_ACK;
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            rd_q <= rd_data;
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        ptr_q <= idx_dec;
                        we_q  <= we_i;
                        sel_q <= sel_i;
                        ret_q <= dec_err ? RETURN_ERR : RETURN_ACK;
                        cnt_q <= '0;
                    end
                end
                ST_WAIT:  cnt_q <= cnt_q + WAIT_CNT_W'(1);
                ST_RESP:  ptr_q <= ptr_q + IDX_W'(1);
                ST_BURST: if (beat) ptr_q <= ptr_q + IDX_W'(1);
            endcase
        end
    end

    wb_regfile_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .GRANULE    (GRANULE),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W),
        .RESET_VALUE(RESET_VALUE)
    ) u_core (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_en  (wr_en),
        .wr_idx (ptr_q),
        .wr_sel (wr_sel),
        .wr_data(dat_i),
        .rd_idx (rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Scoreboard bench for wb_slave_regfile: slave A (no RO) and
// slave B (register 2 read-only) share one master bus.
module tb_wb_slave_regfile;
    import wb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int W  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we, cyc, stb, tgt;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [DW-1:0] dat_a, dat_b;
    logic          ack_a, err_a, ack_b, err_b;

    int checks = 0;
    int errors = 0;
    int cnt = 0;

    typedef struct {
        logic          is_err;
        logic [DW-1:0] data;
        int            cyc;
        int            tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    wb_slave_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8),
        .NUM_REGS(16), .BASE_ADDR(0), .WAIT_STATES(W),
        .RO_MASK(16'h0000), .RESET_VALUE(32'h0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_a), .sel_i(sel), .we_i(we), .cyc_i(cyc & ~tgt),
        .stb_i(stb), .cti_i(cti), .bte_i(bte),
        .ack_o(ack_a), .err_o(err_a)
    );

    wb_slave_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8),
        .NUM_REGS(16), .BASE_ADDR(0), .WAIT_STATES(W),
        .RO_MASK(16'h0004), .RESET_VALUE(32'h0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(dat),
        .dat_o(dat_b), .sel_i(sel), .we_i(we), .cyc_i(cyc & tgt),
        .stb_i(stb), .cti_i(cti), .bte_i(bte),
        .ack_o(ack_b), .err_o(err_b)
    );

    logic          m_ack, m_err;
    logic [DW-1:0] m_dat;
    exp_t          m_e;

    always @(negedge clk) begin
        m_ack = tgt ? ack_b : ack_a;
        m_err = tgt ? err_b : err_a;
        m_dat = tgt ? dat_b : dat_a;
        if (tgt ? (ack_a | err_a) : (ack_b | err_b)) begin
            checks++;
            errors++;
            $display("FAIL stray: unselected slave terminated at cycle %0d, required none", cnt);
        end
        if (m_ack | m_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected: ack=%0b err=%0b at cycle %0d, required no termination",
                         m_ack, m_err, cnt);
            end else begin
                m_e = sb.pop_front();
                checks++;
                if (m_err != m_e.is_err || m_ack != !m_e.is_err) begin
                    errors++;
                    $display("FAIL resp tag %0d: ack=%0b err=%0b, required err=%0b",
                             m_e.tag, m_ack, m_err, m_e.is_err);
                end
                checks++;
                if (cnt != m_e.cyc) begin
                    errors++;
                    $display("FAIL latency tag %0d: cycle %0d, required %0d",
                             m_e.tag, cnt, m_e.cyc);
                end
                checks++;
                if (m_dat !== m_e.data) begin
                    errors++;
                    $display("FAIL data tag %0d: dat_o=%08h, required %08h",
                             m_e.tag, m_dat, m_e.data);
                end
            end
        end
    end

    task automatic push_exp(input logic e, input logic [DW-1:0] d,
                            input int beat, input int tag);
        exp_t x;
        x.is_err = e;
        x.data   = d;
        x.cyc    = cnt + 1 + W + beat;
        x.tag    = tag;
        sb.push_back(x);
    endtask

    task automatic drive_req(input logic t, input logic [AW-1:0] a,
                             input logic w, input logic [SW-1:0] s,
                             input logic [DW-1:0] d, input logic [2:0] c,
                             input logic [1:0] b);
        @(posedge clk);
        #1;
        tgt = t; adr = a; we = w; sel = s; dat = d;
        cti = c; bte = b; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        cti = CTI_CLASSIC; bte = BTE_LINEAR; adr = '0; dat = '0;
    endtask

    task automatic wait_term(input int tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tgt ? (ack_b | err_b) : (ack_a | err_a)) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout tag %0d: no termination in 20 cycles, required one", tag);
            if (sb.size() > 0) sb.delete(0);
        end
    endtask

    task automatic classic(input logic t, input logic [AW-1:0] a,
                           input logic w, input logic [SW-1:0] s,
                           input logic [DW-1:0] d, input logic [1:0] b,
                           input logic e, input logic [DW-1:0] x,
                           input int tag);
        drive_req(t, a, w, s, d, (b != 2'b00) ? CTI_INCR : CTI_CLASSIC, b);
        push_exp(e, x, 0, tag);
        wait_term(tag);
        idle_bus();
    endtask

    // n beats from a; beats below n_ok ACK with base+beat, later ERR
    task automatic burst_read(input logic [AW-1:0] a, input int n,
                              input int n_ok, input logic [DW-1:0] base,
                              input int tag);
        drive_req(1'b0, a, 1'b0, 4'hF, '0, CTI_INCR, BTE_LINEAR);
        for (int b = 0; b < n; b++) begin
            if (b < n_ok) push_exp(1'b0, base + DW'(b), b, tag + b);
            else          push_exp(1'b1, '0, b, tag + b);
        end
        for (int b = 0; b < n; b++) begin
            wait_term(tag + b);
            if (b < n - 1) begin
                @(posedge clk);
                #1;
                adr = adr + AW'(4);
                cti = (b + 1 == n - 1 && n_ok == n) ? CTI_EOB : CTI_INCR;
            end
        end
        idle_bus();
    endtask

    initial begin
        tgt = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack_a, err_a, ack_b, err_b} != 4'b0 || dat_a != '0 || dat_b != '0) begin
            errors++;
            $display("FAIL reset: ack/err=%b dat_a=%08h dat_b=%08h, required all 0",
                     {ack_a, err_a, ack_b, err_b}, dat_a, dat_b);
        end
        rst = 1'b0;

        classic(0, 16'h0004, 1, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0, 1);
        classic(0, 16'h0004, 0, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 2);
        classic(0, 16'h0008, 1, 4'h5, 32'h11223344, 0, 0, 32'h0, 3);
        classic(0, 16'h0008, 0, 4'h0, 32'h0, 0, 0, 32'h00220044, 4);
        classic(0, 16'h0004, 1, 4'h0, 32'h0, 0, 0, 32'h0, 5);
        classic(0, 16'h0004, 0, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF, 6);

        classic(1, 16'h0008, 1, 4'hF, 32'hCAFEF00D, 0, 1, 32'h0, 7);
        classic(1, 16'h0008, 1, 4'h0, 32'hCAFEF00D, 0, 0, 32'h0, 8);
        classic(1, 16'h0008, 0, 4'hF, 32'h0, 0, 0, 32'h0, 9);
        classic(1, 16'h0041, 0, 4'hF, 32'h0, 0, 1, 32'h0, 10);
        classic(1, 16'h0040, 0, 4'hF, 32'h0, 0, 1, 32'h0, 11);
        classic(1, 16'h0040, 1, 4'hF, 32'h1, 0, 1, 32'h0, 12);
        classic(1, 16'h000C, 1, 4'hF, 32'h12345678, 0, 0, 32'h0, 13);
        classic(1, 16'h000C, 0, 4'hF, 32'h0, 0, 0, 32'h12345678, 14);

        for (int i = 0; i < 4; i++) begin
            classic(0, AW'(16'h0030 + 4 * i), 1, 4'hF, DW'(10 + i),
                    0, 0, 32'h0, 20 + i);
        end
        burst_read(16'h0030, 4, 4, 32'hA, 30);
        burst_read(16'h0030, 5, 4, 32'hA, 40);
        classic(0, 16'h0030, 0, 4'hF, 32'h0, 2'b01, 1, 32'h0, 50);

        drive_req(0, 16'h0014, 1, 4'hF, 32'h55, CTI_CLASSIC, BTE_LINEAR);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (4) @(posedge clk);
        classic(0, 16'h0014, 0, 4'hF, 32'h0, 0, 0, 32'h0, 51);

        drive_req(0, 16'h0018, 1, 4'hF, 32'h66, CTI_CLASSIC, BTE_LINEAR);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0;
        #1;
        checks++;
        if (ack_a != 1'b0 || err_a != 1'b0 || dat_a != '0) begin
            errors++;
            $display("FAIL midreset: ack=%0b err=%0b dat=%08h, required 0",
                     ack_a, err_a, dat_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        classic(0, 16'h0018, 0, 4'hF, 32'h0, 0, 0, 32'h0, 52);
        classic(0, 16'h0004, 0, 4'hF, 32'h0, 0, 0, 32'h0, 53);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected terminations outstanding, required 0",
                     sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
